// File: rtl/alu_pkg.sv
// Shared encodings for the ALU front end: operand sizes, flag bit positions
// and the arbiter sequencing states.
package alu_pkg;

   localparam int ALU_SEL_W = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_WORD = 2'b01;
   localparam logic [1:0] SZ_LONG = 2'b10;

   localparam int F_X = 4;
   localparam int F_N = 3;
   localparam int F_Z = 2;
   localparam int F_V = 1;
   localparam int F_C = 0;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response handshake bundle between requesters and alu_arbiter.
// The master side is the requester/consumer population, slave is the arbiter.
interface alu_arbiter_if #(
   parameter int NREQ = 2,
   parameter int W    = 32
) ();
   import alu_pkg::*;

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ*W-1:0]         req_a;
   logic [NREQ*W-1:0]         req_b;
   logic [NREQ*2-1:0]         req_size;
   logic [NREQ*ALU_SEL_W-1:0] req_sel;
   logic [NREQ-1:0]           req_upd_ccr;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [IDW-1:0]            rsp_id;
   logic [W-1:0]              rsp_result;
   logic [4:0]                rsp_xnzvc;

   modport master (
      output req_valid, req_a, req_b, req_size, req_sel, req_upd_ccr, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_xnzvc
   );

   modport slave (
      input  req_valid, req_a, req_b, req_size, req_sel, req_upd_ccr, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_xnzvc
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, returned both one-hot and as an index.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   logic [IDW-1:0] idx_s;
   logic           found_s;

   // Scan NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      idx_s     = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx_s = IDW'((int'(ptr) + i) % NREQ);
         if (!found_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared ALU: one op in flight, registered ALU
// operands, captured result/flags on a response handshake, and the CCR.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_arbiter_if.slave         bus,
   output logic [W-1:0]         alu_a,
   output logic [W-1:0]         alu_b,
   output logic [1:0]           alu_size,
   output logic [ALU_SEL_W-1:0] alu_sel,
   input  logic [W-1:0]         alu_result,
   input  logic [4:0]           alu_xnzvc,
   output logic [4:0]           ccr
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]           state_r;
   logic [IDW-1:0]       rr_ptr_r;
   logic                 upd_ccr_r;
   logic [IDW-1:0]       rsp_id_r;
   logic                 rsp_valid_r;
   logic [W-1:0]         rsp_result_r;
   logic [4:0]           rsp_xnzvc_r;
   logic [W-1:0]         alu_a_r;
   logic [W-1:0]         alu_b_r;
   logic [1:0]           alu_size_r;
   logic [ALU_SEL_W-1:0] alu_sel_r;
   logic [4:0]           ccr_r;

   logic [NREQ-1:0]      grant_s;
   logic [IDW-1:0]       grant_idx_s;
   logic                 hs_s;
   logic [IDW-1:0]       nxt_ptr_s;
   logic [W-1:0]         sel_a_s;
   logic [W-1:0]         sel_b_s;
   logic [1:0]           sel_size_s;
   logic [ALU_SEL_W-1:0] sel_op_s;
   logic                 sel_upd_s;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // rst_n gating keeps req_ready low while reset is held, even with valids up.
   assign bus.req_ready  = grant_s & {NREQ{(state_r == ST_IDLE) & rst_n}};
   assign hs_s           = |(bus.req_valid & bus.req_ready);
   assign nxt_ptr_s      = (grant_idx_s == IDW'(NREQ - 1)) ? IDW'(0) : grant_idx_s + IDW'(1);

   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_result = rsp_result_r;
   assign bus.rsp_xnzvc  = rsp_xnzvc_r;
   assign alu_a          = alu_a_r;
   assign alu_b          = alu_b_r;
   assign alu_size       = alu_size_r;
   assign alu_sel        = alu_sel_r;
   assign ccr            = ccr_r;

   // Extract the granted requester's payload from the packed buses.
   always_comb begin
      sel_a_s    = bus.req_a[int'(grant_idx_s)*W +: W];
      sel_b_s    = bus.req_b[int'(grant_idx_s)*W +: W];
      sel_size_s = bus.req_size[int'(grant_idx_s)*2 +: 2];
      sel_op_s   = bus.req_sel[int'(grant_idx_s)*ALU_SEL_W +: ALU_SEL_W];
      sel_upd_s  = bus.req_upd_ccr[grant_idx_s];
   end

   // Sequencer: IDLE accepts, EXEC captures ALU output, RESP waits for consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         rr_ptr_r     <= '0;
         upd_ccr_r    <= 1'b0;
         rsp_id_r     <= '0;
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= '0;
         rsp_xnzvc_r  <= 5'b00000;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
         alu_size_r   <= 2'b00;
         alu_sel_r    <= '0;
         ccr_r        <= 5'b00000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (hs_s) begin
                  alu_a_r    <= sel_a_s;
                  alu_b_r    <= sel_b_s;
                  alu_size_r <= sel_size_s;
                  alu_sel_r  <= sel_op_s;
                  upd_ccr_r  <= sel_upd_s;
                  rsp_id_r   <= grant_idx_s;
                  rr_ptr_r   <= nxt_ptr_s;
                  state_r    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result_r <= alu_result;
               rsp_xnzvc_r  <= alu_xnzvc;
               rsp_valid_r  <= 1'b1;
               if (upd_ccr_r) begin
                  ccr_r <= alu_xnzvc;
               end
               state_r <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the DUT's ALU
// inputs, and a monitor compares each response against a queued prediction.
module tb_alu_arbiter;
   localparam int NREQ = 2;
   localparam int W    = 32;
   localparam int IDW  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   logic [W-1:0] alu_a_s, alu_b_s, alu_result_s;
   logic [1:0]   alu_size_s;
   logic [3:0]   alu_sel_s;
   logic [4:0]   alu_xnzvc_s, ccr_s;

   alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_size(alu_size_s), .alu_sel(alu_sel_s),
      .alu_result(alu_result_s), .alu_xnzvc(alu_xnzvc_s), .ccr(ccr_s)
   );

   // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass a; size 11 treated as long.
   function automatic logic [W+4:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] sz, input logic [3:0] op);
      int nb;
      logic [W:0] full;
      logic [W-1:0] mask, am, bm, r;
      logic sa, sb, sr, c, v;
      nb = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : W;
      mask = (nb == W) ? {W{1'b1}} : W'((64'd1 << nb) - 64'd1);
      am = a & mask;
      bm = b & mask;
      sa = am[nb-1];
      sb = bm[nb-1];
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: full = {1'b0, am} + {1'b0, bm};
         4'd1: full = {1'b0, am} - {1'b0, bm};
         4'd2: full = {1'b0, am & bm};
         4'd3: full = {1'b0, am | bm};
         4'd4: full = {1'b0, am ^ bm};
         default: full = {1'b0, am};
      endcase
      r  = full[W-1:0] & mask;
      sr = r[nb-1];
      if (op == 4'd0) begin
         c = full[nb];
         v = (sa == sb) && (sr != sa);
      end else if (op == 4'd1) begin
         c = full[nb];
         v = (sa != sb) && (sr != sa);
      end
      return {c, sr, (r == '0), v, c, r};
   endfunction

   always_comb {alu_xnzvc_s, alu_result_s} = alu_fn(alu_a_s, alu_b_s, alu_size_s, alu_sel_s);

   // Requester-side stimulus state
   logic [NREQ-1:0] pvalid = '0;
   logic [W-1:0]    pa [NREQ];
   logic [W-1:0]    pb [NREQ];
   logic [1:0]      psz [NREQ];
   logic [3:0]      psel [NREQ];
   logic [NREQ-1:0] pupd = '0;
   logic            rsp_rdy = 1'b1;
   logic [NREQ-1:0] stream_mask = '0;
   logic            rand_en = 1'b0;
   logic            rand_rsp = 1'b0;
   logic            tput_on = 1'b0;

   assign bus.req_valid   = pvalid;
   assign bus.req_upd_ccr = pupd;
   assign bus.rsp_ready   = rsp_rdy;
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*W +: W]    = pa[i];
         bus.req_b[i*W +: W]    = pb[i];
         bus.req_size[i*2 +: 2] = psz[i];
         bus.req_sel[i*4 +: 4]  = psel[i];
      end
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (last + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   // Scoreboard and monitor
   typedef struct {
      int id;
      logic [W-1:0] a, b, res;
      logic [1:0] sz;
      logic [3:0] op;
      logic [4:0] fl, ccr;
   } exp_t;

   exp_t exp_q[$];
   exp_t hs_e;
   int cyc = 0, since_hs = 0, last_hs = -1, m_last = NREQ - 1;
   logic [4:0] m_ccr = 5'b00000;
   logic hold_v = 1'b0;
   logic [IDW-1:0] h_id;
   logic [W-1:0] h_res;
   logic [4:0] h_fl;

   always @(negedge clk) begin
      logic [NREQ-1:0] hs, ev;
      int g;
      exp_t e, p;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         m_ccr = 5'b00000;
         m_last = NREQ - 1;
         since_hs = 0;
         last_hs = -1;
         hold_v = 1'b0;
      end else begin
         if (since_hs == 1) begin
            chk("exec_alu_a", 64'(alu_a_s), 64'(hs_e.a));
            chk("exec_alu_b", 64'(alu_b_s), 64'(hs_e.b));
            chk("exec_alu_size", 64'(alu_size_s), 64'(hs_e.sz));
            chk("exec_alu_sel", 64'(alu_sel_s), 64'(hs_e.op));
            chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         end else if (since_hs == 2) begin
            chk("latency_rsp_valid", 64'(bus.rsp_valid), 64'd1);
         end
         since_hs = (since_hs == 0 || since_hs == 2) ? 0 : since_hs + 1;

         if (hold_v) begin
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_id", 64'(bus.rsp_id), 64'(h_id));
            chk("hold_result", 64'(bus.rsp_result), 64'(h_res));
            chk("hold_xnzvc", 64'(bus.rsp_xnzvc), 64'(h_fl));
         end
         hold_v = bus.rsp_valid && !rsp_rdy;
         h_id = bus.rsp_id;
         h_res = bus.rsp_result;
         h_fl = bus.rsp_xnzvc;

         if (bus.rsp_valid) chk("ready_low_in_resp", 64'(bus.req_ready), 64'd0);

         if (bus.rsp_valid && rsp_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_response", 64'd1, 64'd0);
            end else begin
               p = exp_q.pop_front();
               chk("rsp_id", 64'(bus.rsp_id), 64'(p.id));
               chk("rsp_result", 64'(bus.rsp_result), 64'(p.res));
               chk("rsp_xnzvc", 64'(bus.rsp_xnzvc), 64'(p.fl));
               chk("ccr", 64'(ccr_s), 64'(p.ccr));
            end
         end

         if (bus.req_ready != '0) chk("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
         g = model_grant(bus.req_valid, m_last);
         if (bus.req_valid != '0 && !bus.rsp_valid && since_hs == 0) begin
            ev = '0;
            ev[g] = 1'b1;
            chk("grant", 64'(bus.req_ready), 64'(ev));
         end

         hs = bus.req_valid & bus.req_ready;
         if (hs != '0 && g >= 0) begin
            e.id = g;
            e.a = pa[g];
            e.b = pb[g];
            e.sz = psz[g];
            e.op = psel[g];
            {e.fl, e.res} = alu_fn(pa[g], pb[g], psz[g], psel[g]);
            if (pupd[g]) m_ccr = e.fl;
            e.ccr = m_ccr;
            exp_q.push_back(e);
            hs_e = e;
            since_hs = 1;
            m_last = g;
            if (tput_on) begin
               if (last_hs >= 0) chk("throughput", 64'(cyc - last_hs), 64'd3);
               last_hs = cyc;
            end else begin
               last_hs = -1;
            end
         end
      end
   end

   // Stimulus
   task automatic new_payload(input int i);
      int k;
      k = $urandom_range(0, 5);
      pa[i] = (k == 0) ? 32'h0000_0000 : (k == 1) ? 32'hFFFF_FFFF : (k == 2) ? 32'h8000_0000 : $urandom;
      pb[i] = (k == 3) ? 32'h0000_0000 : (k == 4) ? 32'h7FFF_FFFF : $urandom;
      psz[i] = 2'($urandom_range(0, 3));
      psel[i] = 4'($urandom_range(0, 7));
      pupd[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic step(output logic [NREQ-1:0] acc);
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) pvalid[i] = 1'b0;
         if (!pvalid[i] && (stream_mask[i] || (rand_en && $urandom_range(0, 2) == 0))) begin
            new_payload(i);
            pvalid[i] = 1'b1;
         end
      end
      if (rand_rsp) rsp_rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] sz, input logic [3:0] op, input logic upd);
      logic [NREQ-1:0] acc;
      int n;
      pa[i] = a;
      pb[i] = b;
      psz[i] = sz;
      psel[i] = op;
      pupd[i] = upd;
      pvalid[i] = 1'b1;
      n = 0;
      while (pvalid[i] && n < 30) begin
         step(acc);
         n++;
      end
      if (pvalid[i]) begin
         nvec++;
         nerr++;
         $display("FAIL issue_timeout: req %0d not accepted after %0d cycles", i, n);
         pvalid[i] = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 20);
      chk("wait_rsp_valid", 64'(bus.rsp_valid), 64'd1);
   endtask

   task automatic drain();
      logic [NREQ-1:0] acc;
      int n;
      stream_mask = '0;
      rand_en = 1'b0;
      rand_rsp = 1'b0;
      tput_on = 1'b0;
      rsp_rdy = 1'b1;
      n = 0;
      while ((pvalid != '0 || exp_q.size() != 0 || bus.rsp_valid) && n < 60) begin
         step(acc);
         n++;
      end
      chk("drain_done", 64'(pvalid != '0 || exp_q.size() != 0), 64'd0);
   endtask

   initial begin
      logic [NREQ-1:0] acc;
      for (int i = 0; i < NREQ; i++) begin
         pa[i] = '0;
         pb[i] = '0;
         psz[i] = 2'b00;
         psel[i] = 4'd0;
      end
      #1;
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_ccr", 64'(ccr_s), 64'd0);
      chk("reset_alu_a", 64'(alu_a_s), 64'd0);
      chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
      #22 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed ops from the test plan
      issue(0, 32'h7FFF_FFFF, 32'h0000_0010, 2'b10, 4'd0, 1'b1);
      wait_rsp();
      chk("t1_result", 64'(bus.rsp_result), 64'h8000_000F);
      chk("t1_xnzvc", 64'(bus.rsp_xnzvc), 64'b01010);
      chk("t1_id", 64'(bus.rsp_id), 64'd0);
      chk("t1_ccr", 64'(ccr_s), 64'b01010);
      issue(1, 32'hF000_0000, 32'h8000_0000, 2'b10, 4'd0, 1'b0);
      wait_rsp();
      chk("t2_result", 64'(bus.rsp_result), 64'h7000_0000);
      chk("t2_xnzvc", 64'(bus.rsp_xnzvc), 64'b10011);
      chk("t2_id", 64'(bus.rsp_id), 64'd1);
      chk("t2_ccr", 64'(ccr_s), 64'b01010);
      drain();

      // Both requesters streaming: alternating grants, 3 cycles per op
      stream_mask = 2'b11;
      tput_on = 1'b1;
      repeat (24) step(acc);
      drain();

      // Single requester streaming
      stream_mask = 2'b01;
      tput_on = 1'b1;
      repeat (18) step(acc);
      drain();

      // Consumer stall in RESP
      rsp_rdy = 1'b0;
      issue(0, 32'h0000_00FF, 32'h0000_0001, 2'b00, 4'd0, 1'b1);
      pa[1] = 32'h1234_5678;
      pb[1] = 32'h0000_0008;
      psz[1] = 2'b01;
      psel[1] = 4'd1;
      pupd[1] = 1'b1;
      pvalid[1] = 1'b1;
      wait_rsp();
      for (int k = 0; k < 5; k++) begin
         step(acc);
         chk("stall_no_accept", 64'(acc), 64'd0);
      end
      rsp_rdy = 1'b1;
      step(acc);
      chk("release_cycle", 64'(acc), 64'd0);
      step(acc);
      chk("idle_after_release", 64'(acc), 64'b10);
      drain();

      // Randomised traffic with random consumer back-pressure
      rand_en = 1'b1;
      rand_rsp = 1'b1;
      repeat (400) step(acc);
      drain();

      // Async reset during EXEC
      issue(0, 32'h7FFF_FFFF, 32'h0000_0010, 2'b10, 4'd0, 1'b1);
      wait_rsp();
      drain();
      issue(0, 32'h0000_0001, 32'h0000_0002, 2'b10, 4'd0, 1'b1);
      pa[1] = 32'h5;
      pb[1] = 32'h6;
      pvalid[1] = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_ccr", 64'(ccr_s), 64'd0);
      chk("rst_alu_a", 64'(alu_a_s), 64'd0);
      chk("rst_alu_b", 64'(alu_b_s), 64'd0);
      chk("rst_alu_size_sel", 64'({alu_size_s, alu_sel_s}), 64'd0);
      chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
      chk("rst_rsp_xnzvc_id", 64'({bus.rsp_xnzvc, bus.rsp_id}), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      pvalid = '0;
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(acc);
         chk("no_rsp_after_reset", 64'(bus.rsp_valid), 64'd0);
         chk("ccr_after_reset", 64'(ccr_s), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
